// File: rtl/bitcalc_sequencer_if.sv
// Handshake and bit-calc lane signals for bitcalc_sequencer.
// The master side is the datapath control together with the 4-bit lane.
interface bitcalc_sequencer_if #(
    parameter int unsigned NIBBLES = 4
);
    localparam int unsigned W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   kind;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         is_zero;
    logic [3:0]   lane_in1;
    logic [3:0]   lane_in2;
    logic [1:0]   lane_kind;
    logic [3:0]   lane_out;
    logic         lane_zero;

    modport master (
        output start, a, b, kind, lane_out, lane_zero,
        input  busy, done, result, is_zero, lane_in1, lane_in2, lane_kind
    );

    modport slave (
        input  start, a, b, kind, lane_out, lane_zero,
        output busy, done, result, is_zero, lane_in1, lane_in2, lane_kind
    );
endinterface

// File: rtl/bitcalc_sequencer.sv
// Sequences one wide bitwise operation through a 4-bit lane, LS nibble first,
// assembling the result and a whole-word zero flag, with a one-cycle done pulse.
module bitcalc_sequencer #(
    parameter int unsigned NIBBLES = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    bitcalc_sequencer_if.slave   bus
);
    localparam int unsigned W    = 4 * NIBBLES;
    localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [1:0]      kind_q;
    logic [IdxW-1:0] idx_q;
    logic            zacc_q;
    logic            busy_q;
    logic            done_q;
    logic            is_zero_q;
    logic [W-1:0]    result_q;
    logic            accept;

    // The done-state exit edge doubles as an accept edge, so back-to-back
    // operations cost N+1 cycles each.
    assign accept = bus.start && (state_q == StIdle || state_q == StDone);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            kind_q    <= 2'b00;
            idx_q     <= '0;
            zacc_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            is_zero_q <= 1'b1;
            result_q  <= '0;
        end else if (accept) begin
            state_q <= StRun;
            a_q     <= bus.a;
            b_q     <= bus.b;
            kind_q  <= bus.kind;
            idx_q   <= '0;
            zacc_q  <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                StRun: begin
                    result_q[4*idx_q +: 4] <= bus.lane_out;
                    zacc_q <= zacc_q & bus.lane_zero;
                    // Operands shift down so the lane always sees bits [3:0];
                    // after the last nibble they are all zero.
                    a_q    <= a_q >> 4;
                    b_q    <= b_q >> 4;
                    if (idx_q == LastIdx) begin
                        state_q   <= StDone;
                        done_q    <= 1'b1;
                        is_zero_q <= zacc_q & bus.lane_zero;
                        kind_q    <= 2'b00;
                        idx_q     <= '0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.is_zero   = is_zero_q;
    assign bus.lane_in1  = a_q[3:0];
    assign bus.lane_in2  = b_q[3:0];
    assign bus.lane_kind = kind_q;
endmodule

// File: tb/tb_bitcalc_sequencer.sv
// Directed bench for bitcalc_sequencer (NIBBLES = 4) with a behavioural 4-bit lane.
module tb_bitcalc_sequencer;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    bitcalc_sequencer_if #(.NIBBLES(4)) bus ();

    bitcalc_sequencer #(.NIBBLES(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural lane: combinational from the sequencer's lane outputs.
    logic [3:0] lane_res;
    always_comb begin
        lane_res = 4'h0;
        case (bus.lane_kind)
            2'b00:   lane_res = bus.lane_in1;
            2'b01:   lane_res = bus.lane_in1 | bus.lane_in2;
            2'b10:   lane_res = bus.lane_in1 & bus.lane_in2;
            default: lane_res = bus.lane_in1 ^ bus.lane_in2;
        endcase
    end
    assign bus.lane_out  = lane_res;
    assign bus.lane_zero = (lane_res == 4'h0);

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  kind;
        logic [15:0] res;
        logic        zero;
        string       name;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag, input logic [15:0] exp_res,
                                      input logic exp_zero);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_result"}, 32'(bus.result), 32'(exp_res));
        check({tag, "_is_zero"}, 32'(bus.is_zero), 32'(exp_zero));
        check({tag, "_lane"}, {22'd0, bus.lane_kind, bus.lane_in2, bus.lane_in1}, 32'd0);
    endtask

    // Pulses START for one cycle; c counts cycles after E0 (c=1 is the first RUN cycle).
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] k,
                         output logic [15:0] res, output logic z, output int done_cyc,
                         output int busy_cyc, output logic [15:0] lane1_seq,
                         output logic kind_ok);
        int c;
        res = 16'hxxxx; z = 1'bx; done_cyc = -1; busy_cyc = 0; lane1_seq = '0; kind_ok = 1'b1;
        @(negedge clk);
        bus.start = 1'b1; bus.a = a; bus.b = b; bus.kind = k;
        @(negedge clk);
        bus.start = 1'b0;
        for (c = 1; c <= 20; c++) begin
            if (bus.busy) busy_cyc++;
            if (bus.done) begin
                done_cyc = c;
                res      = bus.result;
                z        = bus.is_zero;
            end
            if (c <= 4) begin
                lane1_seq[4*(c-1) +: 4] = bus.lane_in1;
                if (bus.lane_kind !== k) kind_ok = 1'b0;
            end
            if (done_cyc > 0 && !bus.busy) break;
            @(negedge clk);
        end
    endtask

    logic [15:0] r;
    logic        z;
    logic        kok;
    logic [15:0] l1;
    int          dc;
    int          bc;
    int          done_seen[$];

    initial begin
        checks = 0; failures = 0;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.kind = 2'b00;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset", 16'h0000, 1'b1);

        vecs[0] = '{16'h1234, 16'h00F0, 2'b01, 16'h12F4, 1'b0, "or"};
        vecs[1] = '{16'hA5A5, 16'hA5A5, 2'b11, 16'h0000, 1'b1, "xor_self"};
        vecs[2] = '{16'hF001, 16'h0001, 2'b10, 16'h0001, 1'b0, "and_low_only"};
        vecs[3] = '{16'hBEEF, 16'hFFFF, 2'b00, 16'hBEEF, 1'b0, "pass"};
        vecs[4] = '{16'h0000, 16'h0000, 2'b01, 16'h0000, 1'b1, "or_zero"};
        vecs[5] = '{16'hFFFF, 16'h0F0F, 2'b10, 16'h0F0F, 1'b0, "and_mask"};
        vecs[6] = '{16'hFFFF, 16'h0000, 2'b11, 16'hFFFF, 1'b0, "xor_ones"};

        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].kind, r, z, dc, bc, l1, kok);
            check({vecs[i].name, "_result"}, 32'(r), 32'(vecs[i].res));
            check({vecs[i].name, "_is_zero"}, 32'(z), 32'(vecs[i].zero));
            check({vecs[i].name, "_done_cycle"}, dc, 32'd5);
            check({vecs[i].name, "_busy_cycles"}, bc, 32'd5);
            check({vecs[i].name, "_lane_in1_seq"}, 32'(l1), 32'(vecs[i].a));
            check({vecs[i].name, "_lane_kind"}, 32'(kok), 32'd1);
            check_idle_outputs({vecs[i].name, "_after"}, vecs[i].res, vecs[i].zero);
        end

        // Busy immunity: START held high, operands scrambled every RUN cycle.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'h1234; bus.b = 16'h00F0; bus.kind = 2'b01;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (bus.done) begin
                done_seen.push_back(c);
                check($sformatf("immune_result_c%0d", c), 32'(bus.result),
                      (c == 5) ? 32'h12F4 : 32'h000F);
                check($sformatf("immune_is_zero_c%0d", c), 32'(bus.is_zero), 32'd0);
            end
            if (c <= 9) check($sformatf("immune_busy_c%0d", c), 32'(bus.busy), 32'd1);
            if (c == 5) begin
                bus.a = 16'h00FF; bus.b = 16'h0F0F; bus.kind = 2'b10;
            end else if (c >= 10) begin
                bus.start = 1'b0;
            end else begin
                bus.a = 16'($urandom); bus.b = 16'($urandom); bus.kind = 2'($urandom);
            end
        end
        check("immune_done_count", done_seen.size(), 32'd2);
        if (done_seen.size() == 2) begin
            check("immune_done1_cycle", done_seen[0], 32'd5);
            check("immune_done2_cycle", done_seen[1], 32'd10);
        end
        check_idle_outputs("immune_after", 16'h000F, 1'b0);

        // Mid-run reset after E2: immediate abort, no done pulse.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'h1234; bus.b = 16'h00F0; bus.kind = 2'b01;
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("midreset_async", 16'h0000, 1'b1);
        dc = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.done) dc++;
            if (c == 2) rst_n = 1'b1;
        end
        check("midreset_no_done", dc, 32'd0);
        check_idle_outputs("midreset_after", 16'h0000, 1'b1);
        do_op(16'h1234, 16'h00F0, 2'b01, r, z, dc, bc, l1, kok);
        check("post_reset_result", 32'(r), 32'h12F4);
        check("post_reset_is_zero", 32'(z), 32'd0);
        check("post_reset_done_cycle", dc, 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
